// File: rtl/decimal_entry_decoder.sv
// decimal_entry_decoder
// Keyed decimal entry front-end: up to four BCD digits are strobed in from
// switches, echoed for the display path, and on Enter converted to a 16-bit
// binary value by an iterative multiply-by-10 accumulate (shift-and-add).
module decimal_entry_decoder #(
    parameter int NDIG = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [3:0]  Digit,
    input  logic        DigitKey,
    input  logic        EnterKey,
    input  logic        ClearKey,
    output logic [15:0] Value,
    output logic        Valid,
    output logic        Busy,
    output logic        Error,
    output logic [2:0]  Count,
    output logic [3:0]  Th,
    output logic [3:0]  H,
    output logic [3:0]  T,
    output logic [3:0]  O
);

    localparam logic [2:0] LP_MAX_DIG = 3'(NDIG);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Key bit order in the conditioning vectors: [2]=Clear, [1]=Enter, [0]=Digit
    logic [2:0]  r_sync1;
    logic [2:0]  r_sync2;
    logic [2:0]  r_sync_d;
    logic [2:0]  w_edge;
    logic        w_edge_clear;
    logic        w_edge_enter;
    logic        w_edge_digit;

    state_t      r_state;
    logic [1:0]  r_idx;
    logic [15:0] r_acc;
    logic [15:0] r_value;
    logic        r_valid;
    logic        r_busy;
    logic        r_error;
    logic [2:0]  r_count;
    logic [3:0]  r_th;
    logic [3:0]  r_h;
    logic [3:0]  r_t;
    logic [3:0]  r_o;

    logic [3:0]  w_cur_digit;
    logic [15:0] w_next_acc;
    logic [2:0]  w_eff_count;

    // Two-flop synchronizer plus one delay stage for rising-edge detection
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1  <= 3'b000;
            r_sync2  <= 3'b000;
            r_sync_d <= 3'b000;
        end else begin
            r_sync1  <= {ClearKey, EnterKey, DigitKey};
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    assign w_edge       = r_sync2 & ~r_sync_d;
    assign w_edge_clear = w_edge[2];
    assign w_edge_enter = w_edge[1];
    assign w_edge_digit = w_edge[0];

    // Select the digit consumed by the current conversion step, most significant first
    always_comb begin
        w_cur_digit = 4'd0;
        case (r_idx)
            2'd0:    w_cur_digit = r_th;
            2'd1:    w_cur_digit = r_h;
            2'd2:    w_cur_digit = r_t;
            2'd3:    w_cur_digit = r_o;
            default: w_cur_digit = 4'd0;
        endcase
    end

    // acc*10 + digit as (acc<<3)+(acc<<1)+digit; 9999 fits so no overflow handling
    assign w_next_acc = (r_acc << 3) + (r_acc << 1) + {12'd0, w_cur_digit};

    // A completed result makes the next digit start a fresh number
    always_comb begin
        w_eff_count = r_count;
        if (r_valid) begin
            w_eff_count = 3'd0;
        end else begin
            w_eff_count = r_count;
        end
    end

    // Entry / conversion FSM with all outputs held in registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_idx   <= 2'd0;
            r_acc   <= 16'd0;
            r_value <= 16'd0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_error <= 1'b0;
            r_count <= 3'd0;
            r_th    <= 4'd0;
            r_h     <= 4'd0;
            r_t     <= 4'd0;
            r_o     <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_edge_clear) begin
                        r_th    <= 4'd0;
                        r_h     <= 4'd0;
                        r_t     <= 4'd0;
                        r_o     <= 4'd0;
                        r_count <= 3'd0;
                        r_error <= 1'b0;
                        r_valid <= 1'b0;
                    end else if (w_edge_enter) begin
                        r_state <= ST_CONV;
                        r_busy  <= 1'b1;
                        r_acc   <= 16'd0;
                        r_idx   <= 2'd0;
                    end else if (w_edge_digit) begin
                        if ((Digit > 4'd9) || (w_eff_count >= LP_MAX_DIG)) begin
                            r_error <= 1'b1;
                        end else if (r_valid) begin
                            r_th    <= 4'd0;
                            r_h     <= 4'd0;
                            r_t     <= 4'd0;
                            r_o     <= Digit;
                            r_count <= 3'd1;
                            r_valid <= 1'b0;
                        end else begin
                            r_th    <= r_h;
                            r_h     <= r_t;
                            r_t     <= r_o;
                            r_o     <= Digit;
                            r_count <= r_count + 3'd1;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CONV: begin
                    r_acc <= w_next_acc;
                    if (r_idx == 2'd3) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + 2'd1;
                    end
                end
                ST_DONE: begin
                    r_value <= r_acc;
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Value = r_value;
    assign Valid = r_valid;
    assign Busy  = r_busy;
    assign Error = r_error;
    assign Count = r_count;
    assign Th    = r_th;
    assign H     = r_h;
    assign T     = r_t;
    assign O     = r_o;

endmodule

// File: tb/tb_decimal_entry_decoder.sv
// Testbench for decimal_entry_decoder: directed scenarios followed by random
// key sequences, all checked against a number-level model of the entry.
module tb_decimal_entry_decoder;

    logic        clock;
    logic        reset_n;
    logic [3:0]  Digit;
    logic        DigitKey;
    logic        EnterKey;
    logic        ClearKey;
    logic [15:0] Value;
    logic        Valid;
    logic        Busy;
    logic        Error;
    logic [2:0]  Count;
    logic [3:0]  Th;
    logic [3:0]  H;
    logic [3:0]  T;
    logic [3:0]  O;

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model: the entry as a list of decimal digits plus status flags
    int m_digs[$];
    int m_value;
    bit m_valid;
    bit m_error;

    decimal_entry_decoder #(.NDIG(4)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .Digit    (Digit),
        .DigitKey (DigitKey),
        .EnterKey (EnterKey),
        .ClearKey (ClearKey),
        .Value    (Value),
        .Valid    (Valid),
        .Busy     (Busy),
        .Error    (Error),
        .Count    (Count),
        .Th       (Th),
        .H        (H),
        .T        (T),
        .O        (O)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int entry_number();
        int n = 0;
        foreach (m_digs[k]) n = n * 10 + m_digs[k];
        return n;
    endfunction

    task automatic model_reset();
        m_digs.delete();
        m_value = 0;
        m_valid = 1'b0;
        m_error = 1'b0;
    endtask

    task automatic model_clear();
        m_digs.delete();
        m_valid = 1'b0;
        m_error = 1'b0;
    endtask

    task automatic model_digit(input int d);
        int eff;
        eff = m_valid ? 0 : m_digs.size();
        if (d > 9 || eff >= 4) begin
            m_error = 1'b1;
        end else begin
            if (m_valid) begin
                m_digs.delete();
                m_valid = 1'b0;
            end
            m_digs.push_back(d);
        end
    endtask

    task automatic model_enter();
        m_value = entry_number();
        m_valid = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = entry_number();
        chk({tag, ".count"}, 32'(Count), 32'(m_digs.size()));
        chk({tag, ".th"},    32'(Th),    32'((n / 1000) % 10));
        chk({tag, ".h"},     32'(H),     32'((n / 100) % 10));
        chk({tag, ".t"},     32'(T),     32'((n / 10) % 10));
        chk({tag, ".o"},     32'(O),     32'(n % 10));
        chk({tag, ".value"}, 32'(Value), 32'(m_value));
        chk({tag, ".valid"}, 32'(Valid), 32'(m_valid));
        chk({tag, ".error"}, 32'(Error), 32'(m_error));
        chk({tag, ".busy"},  32'(Busy),  32'd0);
    endtask

    task automatic press_digit(input int d);
        @(negedge clock);
        Digit    = 4'(d);
        DigitKey = 1'b1;
        repeat (5) @(negedge clock);
        DigitKey = 1'b0;
        repeat (3) @(negedge clock);
        model_digit(d);
    endtask

    task automatic press_clear();
        @(negedge clock);
        ClearKey = 1'b1;
        repeat (5) @(negedge clock);
        ClearKey = 1'b0;
        repeat (3) @(negedge clock);
        model_clear();
    endtask

    // Enter held for several cycles; Busy is sampled on every falling edge
    task automatic press_enter(input string tag);
        int busy_cycles = 0;
        @(negedge clock);
        EnterKey = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (i == 5) EnterKey = 1'b0;
            if (Busy) busy_cycles++;
        end
        model_enter();
        chk({tag, ".busy_cycles"}, 32'(busy_cycles), 32'd5);
    endtask

    initial begin
        int busy_cycles;
        int op;
        Digit    = 4'd0;
        DigitKey = 1'b0;
        EnterKey = 1'b0;
        ClearKey = 1'b0;
        reset_n  = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);
        check_all("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // 1234 -> 0x04D2
        press_digit(1); press_digit(2); press_digit(3); press_digit(4);
        check_all("entry1234");
        press_enter("conv1234");
        check_all("done1234");
        chk("value1234_const", 32'(Value), 32'h04D2);

        // 9999 -> 0x270F, reconversion keeps the result
        press_clear();
        press_digit(9); press_digit(9); press_digit(9); press_digit(9);
        press_enter("conv9999");
        check_all("done9999");
        chk("value9999_const", 32'(Value), 32'h270F);
        press_enter("reconv9999");
        check_all("redone9999");

        // Empty entry converts to zero; next digit starts fresh
        press_clear();
        press_enter("conv_empty");
        check_all("done_empty");
        press_digit(7);
        check_all("fresh7");

        // Fifth digit and non-BCD digit rejected
        press_clear();
        press_digit(1); press_digit(2); press_digit(3); press_digit(4); press_digit(5);
        check_all("fifth_digit");
        press_digit(10);
        check_all("digit_A");
        press_clear();
        check_all("clear_err");

        // Enter and Clear together: Clear wins, no conversion
        press_digit(8);
        busy_cycles = 0;
        @(negedge clock);
        EnterKey = 1'b1;
        ClearKey = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (i == 5) begin
                EnterKey = 1'b0;
                ClearKey = 1'b0;
            end
            if (Busy) busy_cycles++;
        end
        model_clear();
        chk("enter_clear.busy_cycles", 32'(busy_cycles), 32'd0);
        check_all("enter_clear");

        // Digit edge landing inside CONV is lost
        press_digit(3);
        @(negedge clock);
        EnterKey = 1'b1;
        @(negedge clock);
        Digit    = 4'd5;
        DigitKey = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (i == 5) begin
                EnterKey = 1'b0;
                DigitKey = 1'b0;
            end
        end
        model_enter();
        check_all("digit_in_conv");

        // Asynchronous reset in the 2nd CONV cycle
        press_clear();
        press_digit(5); press_digit(6);
        @(negedge clock);
        EnterKey = 1'b1;
        repeat (4) @(negedge clock);
        chk("conv_before_reset.busy", 32'(Busy), 32'd1);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        EnterKey = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        press_enter("conv_after_reset");
        check_all("done_after_reset");

        // Random key sequences
        for (int r = 0; r < 60; r++) begin
            op = int'($urandom_range(0, 9));
            if (op < 6) begin
                press_digit(int'($urandom_range(0, 11)));
            end else if (op < 8) begin
                press_enter("rand_conv");
            end else begin
                press_clear();
            end
            check_all("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
